operand_stage: RTL and testbench
================================

OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameter DWIDTH, default 32, datapath width.
REQ-002 Parameter NREGS, default 32, architectural register count (x0..x31).
REQ-003 Ports, in order:
- clk  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- id_valid_i  in  1  decode slot holds a real instruction.
- rs1_i, rs2_i  in  5 each  source register indices.
- imm_i, pc_i  in  DWIDTH each  decoded immediate and PC.
- op_a_sel_i  in  2  operand A source: RS1, PC, ZERO.
- op_b_sel_i  in  1  operand B source: RS2, IMM.
- alu_op_i  in  4  ALU opcode from the shared constants.
- rd_i  in  5  destination register index.
- rd_wen_i  in  1  instruction writes rd.
- is_load_i  in  1  instruction is a load.
- ex_result_i  in  DWIDTH  ALU result of the instruction currently in EX.
- mem_rd_i  in  5, mem_wen_i  in  1, mem_data_i  in  DWIDTH  MEM-stage destination, write enable and final value.
- wb_rd_i  in  5, wb_wen_i  in  1, wb_data_i  in  DWIDTH  WB-stage register write port.
- flush_i  in  1  squash the decode slot (taken branch or jump).
- stall_o  out  1  hold fetch/decode this cycle.
- ex_valid_o, ex_alu_op_o, ex_operand_a_o, ex_operand_b_o  out  1/4/DWIDTH/DWIDTH  registered EX-stage controls and operands.
- ex_store_data_o  out  DWIDTH  forwarded rs2 value.
- ex_rd_o, ex_rd_wen_o, ex_is_load_o  out  5/1/1  registered destination info.

Function
REQ-004 The block SHALL hold a NREGS x DWIDTH register file written only when wb_wen_i=1 and wb_rd_i!=0, on the rising edge of clk.
REQ-005 Reads of x0 SHALL return 0 and SHALL never be forwarded, regardless of any matching rd.
REQ-006 A source value SHALL be resolved with this priority: EX (ex_valid_o & ex_rd_wen_o & ~ex_is_load_o & ex_rd_o==rs), then MEM (mem_wen_i & mem_rd_i==rs), then WB (wb_wen_i & wb_rd_i==rs), then the register file.
REQ-007 Operand A SHALL be resolved rs1, pc_i or 0 per op_a_sel_i; operand B SHALL be resolved rs2 or imm_i per op_b_sel_i; ex_store_data_o SHALL always carry the resolved rs2.
REQ-008 Load-use hazard: stall_o SHALL be 1 combinationally when all of the following hold: id_valid_i=1, ex_valid_o=1, ex_is_load_o=1, ex_rd_o!=0, and ex_rd_o matches an rs that is actually used (rs1 when op_a_sel=RS1; rs2 when op_b_sel=RS2 or is_load_i=0 store path).
REQ-009 The EX register SHALL update every cycle with 1-cycle latency from decode inputs.
REQ-010 On the next edge the EX register SHALL load ex_valid_o = id_valid_i & ~stall_o & ~flush_i; when the result is 0 the edge SHALL load ex_rd_wen_o=0 and ex_is_load_o=0 (bubble).
REQ-011 flush_i SHALL override stall: when flush_i=1, stall_o SHALL be 0 and a bubble SHALL be inserted.
REQ-012 Simultaneous WB write and ID read of the same non-zero register SHALL yield wb_data_i in the same cycle (write-through bypass).
REQ-013 ex_operand_* SHALL be plain DWIDTH-bit values with no sign or width transformation.

Reset
REQ-014 While reset=1 at an edge, all ex_* outputs SHALL become 0 and all registers SHALL clear to 0.
REQ-015 stall_o SHALL be 0 in the cycle following reset.
REQ-016 Reset asserted mid-stall SHALL discard the stalled instruction.

Structure
REQ-017 The op_a_sel and op_b_sel enums SHALL live in the shared constants package, alongside the existing ALU opcodes.
REQ-018 The register file SHALL be a sub-module named regfile, with 2 read ports, 1 write port and the bypass logic.
REQ-019 Hazard detection and forwarding muxes SHALL reside in operand_stage.

Verification
REQ-020 Write x5=0x1234 through WB, then decode an instruction with rs1=5 and op_a=RS1 -> ex_operand_a_o=0x1234 one cycle later.
REQ-021 EX holds a non-load with rd=3 and ex_result_i=7, MEM has rd=3 with data 9, and rs1=3 -> operand A=7 (EX wins).
REQ-022 EX holds a load with rd=4, and rs2=4 with op_b=RS2 -> stall_o=1 for one cycle and ex_valid_o=0; the next cycle resolves via MEM forwarding to mem_data_i.
REQ-023 WB writes x0=0xFFFF and decode has rs1=0 -> operand A=0, and no stall occurs even if the EX load has rd=0.
REQ-024 flush_i=1 during a load-use condition -> stall_o=0, and ex_valid_o=0 next cycle.
REQ-025 reset pulsed while stall_o=1 -> all ex_* outputs=0, and reading x1 afterwards returns 0.

Source files
------------

// File: rtl/operand_stage_pkg.sv
// Shared constants for the operand stage: ALU opcodes, operand source selects
// and the forwarding-hit helper used by the bypass network.
package operand_stage_pkg;

    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        OPA_RS1  = 2'd0,
        OPA_PC   = 2'd1,
        OPA_ZERO = 2'd2
    } op_a_sel_e;

    typedef enum logic {
        OPB_RS2 = 1'b0,
        OPB_IMM = 1'b1
    } op_b_sel_e;

    // x0 is hardwired, so a producer targeting it must never be matched.
    function automatic logic is_fwd_hit(input logic en,
                                        input logic [REG_AW-1:0] rd,
                                        input logic [REG_AW-1:0] rs);
        return en && (rd == rs) && (rs != '0);
    endfunction

endpackage

// File: rtl/operand_stage_regfile.sv
// Architectural register file: two read ports, one write port, x0 hardwired
// to zero and a write-through bypass so a same-cycle write is visible on reads.
module regfile
    import operand_stage_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] ra1_i,
    input  logic [REG_AW-1:0] ra2_i,
    output logic [DWIDTH-1:0] rd1_o,
    output logic [DWIDTH-1:0] rd2_o,
    input  logic              we_i,
    input  logic [REG_AW-1:0] wa_i,
    input  logic [DWIDTH-1:0] wd_i
);

    logic [DWIDTH-1:0] regs_q [NREGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (wa_i != '0)) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    always_comb begin
        rd1_o = regs_q[ra1_i];
        rd2_o = regs_q[ra2_i];
        if (is_fwd_hit(we_i, wa_i, ra1_i)) begin
            rd1_o = wd_i;
        end
        if (is_fwd_hit(we_i, wa_i, ra2_i)) begin
            rd2_o = wd_i;
        end
        if (ra1_i == '0) begin
            rd1_o = '0;
        end
        if (ra2_i == '0) begin
            rd2_o = '0;
        end
    end

endmodule

// File: rtl/operand_stage.sv
// Decode-to-execute operand stage: register read, EX/MEM/WB forwarding,
// load-use stall detection and the EX pipeline register.
module operand_stage
    import operand_stage_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int NREGS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    input  logic [DWIDTH-1:0] imm_i,
    input  logic [DWIDTH-1:0] pc_i,
    input  logic [1:0]        op_a_sel_i,
    input  logic              op_b_sel_i,
    input  logic [3:0]        alu_op_i,
    input  logic [4:0]        rd_i,
    input  logic              rd_wen_i,
    input  logic              is_load_i,
    input  logic [DWIDTH-1:0] ex_result_i,
    input  logic [4:0]        mem_rd_i,
    input  logic              mem_wen_i,
    input  logic [DWIDTH-1:0] mem_data_i,
    input  logic [4:0]        wb_rd_i,
    input  logic              wb_wen_i,
    input  logic [DWIDTH-1:0] wb_data_i,
    input  logic              flush_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic [3:0]        ex_alu_op_o,
    output logic [DWIDTH-1:0] ex_operand_a_o,
    output logic [DWIDTH-1:0] ex_operand_b_o,
    output logic [DWIDTH-1:0] ex_store_data_o,
    output logic [4:0]        ex_rd_o,
    output logic              ex_rd_wen_o,
    output logic              ex_is_load_o
);

    logic [DWIDTH-1:0] rf_rs1, rf_rs2;
    logic [DWIDTH-1:0] rs1_val, rs2_val;
    logic              ex_fwd_en, rs1_used, rs2_used, load_use;

    logic              ex_valid_q,    ex_valid_d;
    logic [3:0]        ex_alu_op_q,   ex_alu_op_d;
    logic [DWIDTH-1:0] ex_opa_q,      ex_opa_d;
    logic [DWIDTH-1:0] ex_opb_q,      ex_opb_d;
    logic [DWIDTH-1:0] ex_store_q,    ex_store_d;
    logic [4:0]        ex_rd_q,       ex_rd_d;
    logic              ex_rd_wen_q,   ex_rd_wen_d;
    logic              ex_is_load_q,  ex_is_load_d;

    regfile #(.DWIDTH(DWIDTH), .NREGS(NREGS)) u_regfile (
        .clk   (clk),
        .reset (reset),
        .ra1_i (rs1_i),
        .ra2_i (rs2_i),
        .rd1_o (rf_rs1),
        .rd2_o (rf_rs2),
        .we_i  (wb_wen_i),
        .wa_i  (wb_rd_i),
        .wd_i  (wb_data_i)
    );

    // A load in EX has no data yet, so it is excluded from forwarding and
    // instead triggers the load-use stall below.
    assign ex_fwd_en = ex_valid_q & ex_rd_wen_q & ~ex_is_load_q;

    always_comb begin
        rs1_val = rf_rs1;
        if (is_fwd_hit(ex_fwd_en, ex_rd_q, rs1_i)) begin
            rs1_val = ex_result_i;
        end else if (is_fwd_hit(mem_wen_i, mem_rd_i, rs1_i)) begin
            rs1_val = mem_data_i;
        end else if (is_fwd_hit(wb_wen_i, wb_rd_i, rs1_i)) begin
            rs1_val = wb_data_i;
        end

        rs2_val = rf_rs2;
        if (is_fwd_hit(ex_fwd_en, ex_rd_q, rs2_i)) begin
            rs2_val = ex_result_i;
        end else if (is_fwd_hit(mem_wen_i, mem_rd_i, rs2_i)) begin
            rs2_val = mem_data_i;
        end else if (is_fwd_hit(wb_wen_i, wb_rd_i, rs2_i)) begin
            rs2_val = wb_data_i;
        end
    end

    // Non-load instructions may carry rs2 as store data even when operand B is the immediate.
    always_comb begin
        rs1_used = (op_a_sel_i == OPA_RS1);
        rs2_used = (op_b_sel_i == OPB_RS2) || !is_load_i;
        load_use = id_valid_i && ex_valid_q && ex_is_load_q && (ex_rd_q != '0) &&
                   ((rs1_used && (rs1_i == ex_rd_q)) || (rs2_used && (rs2_i == ex_rd_q)));
        stall_o  = load_use && !flush_i;
    end

    always_comb begin
        ex_valid_d   = id_valid_i && !stall_o && !flush_i;
        ex_alu_op_d  = alu_op_i;
        ex_rd_d      = rd_i;
        ex_rd_wen_d  = rd_wen_i && ex_valid_d;
        ex_is_load_d = is_load_i && ex_valid_d;
        ex_store_d   = rs2_val;
        ex_opb_d     = (op_b_sel_i == OPB_IMM) ? imm_i : rs2_val;
        case (op_a_sel_i)
            OPA_RS1: ex_opa_d = rs1_val;
            OPA_PC:  ex_opa_d = pc_i;
            default: ex_opa_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid_q   <= 1'b0;
            ex_alu_op_q  <= '0;
            ex_opa_q     <= '0;
            ex_opb_q     <= '0;
            ex_store_q   <= '0;
            ex_rd_q      <= '0;
            ex_rd_wen_q  <= 1'b0;
            ex_is_load_q <= 1'b0;
        end else begin
            ex_valid_q   <= ex_valid_d;
            ex_alu_op_q  <= ex_alu_op_d;
            ex_opa_q     <= ex_opa_d;
            ex_opb_q     <= ex_opb_d;
            ex_store_q   <= ex_store_d;
            ex_rd_q      <= ex_rd_d;
            ex_rd_wen_q  <= ex_rd_wen_d;
            ex_is_load_q <= ex_is_load_d;
        end
    end

    assign ex_valid_o      = ex_valid_q;
    assign ex_alu_op_o     = ex_alu_op_q;
    assign ex_operand_a_o  = ex_opa_q;
    assign ex_operand_b_o  = ex_opb_q;
    assign ex_store_data_o = ex_store_q;
    assign ex_rd_o         = ex_rd_q;
    assign ex_rd_wen_o     = ex_rd_wen_q;
    assign ex_is_load_o    = ex_is_load_q;

endmodule

// File: tb/tb_operand_stage.sv
// Directed bench for operand_stage: register file access, forwarding priority,
// load-use stall, flush, x0 handling and reset behaviour.
module tb_operand_stage;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          idValid;
    logic [4:0]    rs1, rs2, rd, memRd, wbRd;
    logic [DW-1:0] imm, pc, exResult, memData, wbData;
    logic [1:0]    opASel;
    logic          opBSel;
    logic [3:0]    aluOp;
    logic          rdWen, isLoad, memWen, wbWen, flush;
    logic          stall, exValid, exRdWen, exIsLoad;
    logic [3:0]    exAluOp;
    logic [DW-1:0] exOpA, exOpB, exStore;
    logic [4:0]    exRd;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    operand_stage #(.DWIDTH(DW), .NREGS(32)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_valid_i      (idValid),
        .rs1_i           (rs1),
        .rs2_i           (rs2),
        .imm_i           (imm),
        .pc_i            (pc),
        .op_a_sel_i      (opASel),
        .op_b_sel_i      (opBSel),
        .alu_op_i        (aluOp),
        .rd_i            (rd),
        .rd_wen_i        (rdWen),
        .is_load_i       (isLoad),
        .ex_result_i     (exResult),
        .mem_rd_i        (memRd),
        .mem_wen_i       (memWen),
        .mem_data_i      (memData),
        .wb_rd_i         (wbRd),
        .wb_wen_i        (wbWen),
        .wb_data_i       (wbData),
        .flush_i         (flush),
        .stall_o         (stall),
        .ex_valid_o      (exValid),
        .ex_alu_op_o     (exAluOp),
        .ex_operand_a_o  (exOpA),
        .ex_operand_b_o  (exOpB),
        .ex_store_data_o (exStore),
        .ex_rd_o         (exRd),
        .ex_rd_wen_o     (exRdWen),
        .ex_is_load_o    (exIsLoad)
    );

    // Inputs change 1 time unit after the rising edge, so every sample is away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        idValid = 0; rs1 = 0; rs2 = 0; imm = 0; pc = 0; opASel = 2'd0; opBSel = 1'b0;
        aluOp = 0; rd = 0; rdWen = 0; isLoad = 0; exResult = 0; memRd = 0; memWen = 0;
        memData = 0; wbRd = 0; wbWen = 0; wbData = 0; flush = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        tick(); tick();
        reset = 0;
        #1;
        checks++;
        if ({exValid, exRdWen, exIsLoad, stall} !== 4'b0000) begin
            errors++; $display("[TB] FAIL reset_flags got %b want 0000", {exValid, exRdWen, exIsLoad, stall});
        end
        checks++;
        if ({exOpA, exOpB, exStore, exRd, exAluOp} !== '0) begin
            errors++; $display("[TB] FAIL reset_data got %h/%h/%h/%h/%h want 0", exOpA, exOpB, exStore, exRd, exAluOp);
        end
    endtask

    task automatic test_wb_write_read();
        idle_inputs();
        wbWen = 1; wbRd = 5; wbData = 32'h1234;
        tick();
        idle_inputs();
        idValid = 1; rs1 = 5; opASel = 2'd0; opBSel = 1'b1; imm = 32'h10; rd = 6; rdWen = 1; aluOp = 4'd8;
        tick();
        checks++;
        if (exOpA !== 32'h1234) begin
            errors++; $display("[TB] FAIL wb_read_opa got %h want 00001234", exOpA);
        end
        checks++;
        if ({exValid, exRd, exRdWen, exAluOp, exOpB} !== {1'b1, 5'd6, 1'b1, 4'd8, 32'h10}) begin
            errors++; $display("[TB] FAIL wb_read_ctrl got v%b rd%0d w%b op%0d b%h want v1 rd6 w1 op8 b00000010",
                               exValid, exRd, exRdWen, exAluOp, exOpB);
        end
    endtask

    task automatic test_bypass_and_sel();
        idle_inputs();
        idValid = 1; rs2 = 7; opBSel = 1'b0; wbWen = 1; wbRd = 7; wbData = 32'hABCD;
        tick();
        checks++;
        if ({exOpB, exStore} !== {32'hABCD, 32'hABCD}) begin
            errors++; $display("[TB] FAIL wt_bypass got %h/%h want 0000abcd/0000abcd", exOpB, exStore);
        end
        idle_inputs();
        idValid = 1; opASel = 2'd1; pc = 32'h400; rs1 = 5;
        tick();
        checks++;
        if (exOpA !== 32'h400) begin
            errors++; $display("[TB] FAIL opa_pc got %h want 00000400", exOpA);
        end
        opASel = 2'd2;
        tick();
        checks++;
        if (exOpA !== 32'h0) begin
            errors++; $display("[TB] FAIL opa_zero got %h want 00000000", exOpA);
        end
    endtask

    task automatic test_fwd_priority();
        idle_inputs();
        tick();
        idValid = 1; rd = 3; rdWen = 1;
        tick();
        rdWen = 0; rs1 = 3; rs2 = 3; opASel = 2'd0; opBSel = 1'b0;
        exResult = 7; memWen = 1; memRd = 3; memData = 9; wbWen = 1; wbRd = 3; wbData = 11;
        tick();
        checks++;
        if ({exOpA, exOpB, exStore} !== {32'd7, 32'd7, 32'd7}) begin
            errors++; $display("[TB] FAIL fwd_ex got %0d/%0d/%0d want 7/7/7", exOpA, exOpB, exStore);
        end
        tick();
        checks++;
        if (exOpA !== 32'd9) begin
            errors++; $display("[TB] FAIL fwd_mem got %0d want 9", exOpA);
        end
        memWen = 0;
        tick();
        checks++;
        if (exOpA !== 32'd11) begin
            errors++; $display("[TB] FAIL fwd_wb got %0d want 11", exOpA);
        end
        wbWen = 0; exResult = 99;
        tick();
        checks++;
        if (exOpA !== 32'd11) begin
            errors++; $display("[TB] FAIL rf_read got %0d want 11", exOpA);
        end
    endtask

    task automatic test_load_use();
        idle_inputs();
        tick();
        idValid = 1; rd = 4; rdWen = 1; isLoad = 1; opBSel = 1'b1;
        tick();
        isLoad = 0; rd = 8; rs2 = 4; opBSel = 1'b0; exResult = 32'hDEAD;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("[TB] FAIL load_use_stall got %b want 1", stall);
        end
        tick();
        checks++;
        if ({exValid, exRdWen, exIsLoad, stall} !== 4'b0000) begin
            errors++; $display("[TB] FAIL load_use_bubble got %b want 0000", {exValid, exRdWen, exIsLoad, stall});
        end
        memWen = 1; memRd = 4; memData = 32'h55AA;
        tick();
        checks++;
        if ({exValid, exRd, exOpB} !== {1'b1, 5'd8, 32'h55AA}) begin
            errors++; $display("[TB] FAIL load_use_mem got v%b rd%0d b%h want v1 rd8 b000055aa", exValid, exRd, exOpB);
        end
    endtask

    task automatic test_x0();
        idle_inputs();
        tick();
        idValid = 1; rd = 0; rdWen = 1; isLoad = 1; opBSel = 1'b1;
        tick();
        isLoad = 0; rs1 = 0; rs2 = 0; opASel = 2'd0; opBSel = 1'b0;
        wbWen = 1; wbRd = 0; wbData = 32'hFFFF; memWen = 1; memRd = 0; memData = 32'h77; exResult = 32'h33;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("[TB] FAIL x0_no_stall got %b want 0", stall);
        end
        tick();
        checks++;
        if ({exOpA, exOpB} !== 64'h0) begin
            errors++; $display("[TB] FAIL x0_read got %h/%h want 0/0", exOpA, exOpB);
        end
    endtask

    task automatic test_flush();
        idle_inputs();
        tick();
        idValid = 1; rd = 9; rdWen = 1; isLoad = 1; opBSel = 1'b1;
        tick();
        rs1 = 9; rs2 = 9; opASel = 2'd1; opBSel = 1'b1; isLoad = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("[TB] FAIL unused_rs_stall got %b want 0", stall);
        end
        opASel = 2'd0; isLoad = 0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("[TB] FAIL flush_pre_stall got %b want 1", stall);
        end
        flush = 1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("[TB] FAIL flush_stall got %b want 0", stall);
        end
        tick();
        checks++;
        if ({exValid, exRdWen, exIsLoad} !== 3'b000) begin
            errors++; $display("[TB] FAIL flush_bubble got %b want 000", {exValid, exRdWen, exIsLoad});
        end
    endtask

    task automatic test_reset_mid_stall();
        idle_inputs();
        wbWen = 1; wbRd = 1; wbData = 32'hBEEF;
        tick();
        idle_inputs();
        idValid = 1; rd = 2; rdWen = 1; isLoad = 1; opBSel = 1'b1; aluOp = 4'd3; imm = 32'h44;
        tick();
        isLoad = 0; rs1 = 2; opASel = 2'd0;
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("[TB] FAIL mid_stall_pre got %b want 1", stall);
        end
        reset = 1;
        tick();
        reset = 0;
        #1;
        checks++;
        if ({exValid, exRdWen, exIsLoad, exRd, exAluOp, exOpA, exOpB, exStore, stall} !== '0) begin
            errors++; $display("[TB] FAIL mid_stall_reset got v%b rd%0d op%0d a%h b%h s%h stall%b want all 0",
                               exValid, exRd, exAluOp, exOpA, exOpB, exStore, stall);
        end
        idle_inputs();
        idValid = 1; rs1 = 1; opASel = 2'd0;
        tick();
        checks++;
        if (exOpA !== 32'h0) begin
            errors++; $display("[TB] FAIL x1_after_reset got %h want 00000000", exOpA);
        end
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_wb_write_read();
        test_bypass_and_sel();
        test_fwd_priority();
        test_load_use();
        test_x0();
        test_flush();
        test_reset_mid_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
